// File: rtl/pid_sample_sched.sv
// Sample tick generator and P/I/D sequencer sharing one signed multiplier; one saturated u per sample.
// Define PID_DERIV_EN to build the derivative stage (tick-to-u 6 cycles); otherwise P+I only (5 cycles).
module pid_sample_sched #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 8
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 enable,
  input  logic                 clr,
  input  logic [31:0]          period,
  input  logic                 trig,
  input  logic signed [DW-1:0] setpoint,
  input  logic signed [DW-1:0] feedback,
  input  logic signed [CW-1:0] kp,
  input  logic signed [CW-1:0] ki,
  input  logic signed [CW-1:0] kd,
  output logic signed [DW-1:0] u,
  output logic                 u_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int EW = DW + 1;
  localparam int IW = DW + 2;
  localparam int PW = CW + DW + 2;
  localparam int AW = CW + DW + 4;

  localparam logic signed [IW:0]   ISUM_MAX = {2'b00, {(DW+1){1'b1}}};
  localparam logic signed [IW:0]   ISUM_MIN = {2'b11, {DW{1'b0}}, 1'b1};
  localparam logic signed [AW-1:0] U_MAX    = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] U_MIN    = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_MUL_P,
    ST_MUL_I,
`ifdef PID_DERIV_EN
    ST_MUL_D,
`endif
    ST_SUM,
    ST_OUT
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic signed [DW-1:0] sp_q, sp_d, fb_q, fb_d;
  logic signed [EW-1:0] e_q, e_d;
  logic signed [IW-1:0] integ_q, integ_d;
  logic signed [PW-1:0] prod_q, prod_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] u_q, u_d;
  logic                 u_valid_q, u_valid_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;
`ifdef PID_DERIV_EN
  logic signed [EW-1:0] e_prev_q, e_prev_d;
  logic signed [IW-1:0] d_q, d_d;
`else
  logic                 unused_kd;
  assign unused_kd = ^kd;
`endif

  logic [31:0]          eff_period;
  logic                 tick;
  logic signed [CW-1:0] mul_a;
  logic signed [IW-1:0] mul_b;
  logic signed [PW-1:0] mul_res;
  logic signed [EW-1:0] e_new;
  logic signed [IW:0]   isum;
  logic signed [AW-1:0] acc_sh;

  // Free-running sample counter; a counter left above a shrunken period wraps silently.
  always_comb begin
    eff_period = (period < 32'd8) ? 32'd8 : period;
    cnt_d      = cnt_q;
    tick       = 1'b0;
    if (!enable || period == 32'd0) begin
      cnt_d = 32'd0;
      tick  = enable && (period == 32'd0) && trig;
    end else if (cnt_q == eff_period - 32'd1) begin
      cnt_d = 32'd0;
      tick  = 1'b1;
    end else if (cnt_q > eff_period - 32'd1) begin
      cnt_d = 32'd0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_comb begin
    mul_a = kp;
    mul_b = IW'(e_q);
    case (state_q)
      ST_MUL_I: begin
        mul_a = ki;
        mul_b = integ_q;
      end
`ifdef PID_DERIV_EN
      ST_MUL_D: begin
        mul_a = kd;
        mul_b = d_q;
      end
`endif
      default: ;
    endcase
    mul_res = PW'(mul_a) * PW'(mul_b);
  end

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    fb_d      = fb_q;
    e_d       = e_q;
    integ_d   = integ_q;
    prod_d    = prod_q;
    acc_d     = acc_q;
    u_d       = u_q;
    u_valid_d = 1'b0;
    overrun_d = overrun_q;
`ifdef PID_DERIV_EN
    e_prev_d  = e_prev_q;
    d_d       = d_q;
`endif
    e_new  = EW'(sp_q) - EW'(fb_q);
    isum   = (IW+1)'(integ_q) + (IW+1)'(e_new);
    acc_sh = acc_q >>> FRAC;

    if (tick && state_q != ST_IDLE) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          sp_d    = setpoint;
          fb_d    = feedback;
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        e_d = e_new;
        if (isum > ISUM_MAX)      integ_d = ISUM_MAX[IW-1:0];
        else if (isum < ISUM_MIN) integ_d = ISUM_MIN[IW-1:0];
        else                      integ_d = isum[IW-1:0];
`ifdef PID_DERIV_EN
        d_d      = IW'(e_new) - IW'(e_prev_q);
        e_prev_d = e_new;
`endif
        state_d = ST_MUL_P;
      end
      ST_MUL_P: begin
        prod_d  = mul_res;
        state_d = ST_MUL_I;
      end
      ST_MUL_I: begin
        acc_d   = AW'(prod_q);
        prod_d  = mul_res;
`ifdef PID_DERIV_EN
        state_d = ST_MUL_D;
`else
        state_d = ST_SUM;
`endif
      end
`ifdef PID_DERIV_EN
      ST_MUL_D: begin
        acc_d   = acc_q + AW'(prod_q);
        prod_d  = mul_res;
        state_d = ST_SUM;
      end
`endif
      ST_SUM: begin
        acc_d   = acc_q + AW'(prod_q);
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (acc_sh > U_MAX)      u_d = U_MAX[DW-1:0];
        else if (acc_sh < U_MIN) u_d = U_MIN[DW-1:0];
        else                     u_d = acc_sh[DW-1:0];
        u_valid_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // clr wins over everything, including a coincident tick
    if (clr) begin
      state_d   = ST_IDLE;
      integ_d   = '0;
      u_d       = '0;
      acc_d     = '0;
      prod_d    = '0;
      overrun_d = 1'b0;
      u_valid_d = 1'b0;
`ifdef PID_DERIV_EN
      e_prev_d  = '0;
`endif
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sp_q      <= '0;
      fb_q      <= '0;
      e_q       <= '0;
      integ_q   <= '0;
      prod_q    <= '0;
      acc_q     <= '0;
      u_q       <= '0;
      u_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PID_DERIV_EN
      e_prev_q  <= '0;
      d_q       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sp_q      <= sp_d;
      fb_q      <= fb_d;
      e_q       <= e_d;
      integ_q   <= integ_d;
      prod_q    <= prod_d;
      acc_q     <= acc_d;
      u_q       <= u_d;
      u_valid_q <= u_valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
`ifdef PID_DERIV_EN
      e_prev_q  <= e_prev_d;
      d_q       <= d_d;
`endif
    end
  end

  assign u       = u_q;
  assign u_valid = u_valid_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_pid_sample_sched.sv
// Scoreboard bench for pid_sample_sched: a reference PID model queues expected u per accepted sample.
module tb_pid_sample_sched;
  localparam int DW = 16;
  localparam int CW = 16;
`ifdef PID_DERIV_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic                 ACLK = 1'b0;
  logic                 ARESETN, enable, clr, trig;
  logic [31:0]          period;
  logic signed [DW-1:0] setpoint, feedback;
  logic signed [CW-1:0] kp, ki, kd;
  logic signed [DW-1:0] u;
  logic                 u_valid, busy, overrun;

  pid_sample_sched #(.DW(DW), .CW(CW), .FRAC(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .clr(clr), .period(period),
    .trig(trig), .setpoint(setpoint), .feedback(feedback), .kp(kp), .ki(ki), .kd(kd),
    .u(u), .u_valid(u_valid), .busy(busy), .overrun(overrun)
  );

  always #5 ACLK = ~ACLK;

  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;
  int     nvalid = 0;
  longint t_start = 0, last_valid = 0, last_gap = 0;
  longint exp_q[$];
  longint m_integ = 0, m_eprev = 0;
  logic   busy_prev = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: integrator clamps to +-(2^17-1), output to 16-bit signed, gains Q8.
  function automatic longint model_u(input longint sp, input longint fb);
    longint e, d, acc, sh;
    e = sp - fb;
    m_integ = m_integ + e;
    if (m_integ > 131071) m_integ = 131071;
    if (m_integ < -131071) m_integ = -131071;
    d = e - m_eprev;
    m_eprev = e;
    acc = longint'(kp) * e + longint'(ki) * m_integ;
`ifdef PID_DERIV_EN
    acc = acc + longint'(kd) * d;
`endif
    sh = acc >>> 8;
    if (sh > 32767) sh = 32767;
    if (sh < -32768) sh = -32768;
    return sh;
  endfunction

  task automatic push_exp();
    exp_q.push_back(model_u(longint'(setpoint), longint'(feedback)));
  endtask

  task automatic pulse_trig();
    @(negedge ACLK) trig = 1'b1;
    @(negedge ACLK) trig = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge ACLK) clr = 1'b1;
    @(negedge ACLK) clr = 1'b0;
    m_integ = 0;
    m_eprev = 0;
  endtask

  task automatic wait_valid(input int target, input int budget);
    int n = 0;
    while (nvalid < target && n < budget) begin
      @(posedge ACLK);
      n++;
    end
    chk("valid_count", nvalid, target);
  endtask

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(negedge ACLK) begin
    if (busy && !busy_prev) t_start = cyc;
    busy_prev = busy;
    if (u_valid) begin
      chk("exp_available", exp_q.size() > 0, 1);
      chk("latency", cyc - t_start, LAT);
      if (exp_q.size() > 0) chk("u", u, exp_q.pop_front());
      last_gap   = cyc - last_valid;
      last_valid = cyc;
      nvalid++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv = 0;
    ARESETN = 1'b0; enable = 1'b0; clr = 1'b0; trig = 1'b0; period = 32'd0;
    setpoint = '0; feedback = '0; kp = '0; ki = '0; kd = '0;
    repeat (2) @(negedge ACLK);
    chk("rst_u", u, 0);
    chk("rst_u_valid", u_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge ACLK) ARESETN = 1'b1;

    // Proportional path in timer mode
    kp = 16'sh0100; setpoint = 16'sd100; feedback = 16'sd40; period = 32'd20;
    push_exp();
    @(negedge ACLK) enable = 1'b1;
    wait_valid(++nv, 40);
    @(negedge ACLK) enable = 1'b0;
    chk("p_busy_after", busy, 0);

    // Saturation both ways in trig-only mode
    period = 32'd0; kp = 16'sh7FFF;
    @(negedge ACLK) enable = 1'b1;
    setpoint = 16'sd1000; feedback = 16'sd0;
    push_exp(); pulse_trig(); wait_valid(++nv, 20);
    setpoint = -16'sd1000;
    push_exp(); pulse_trig(); wait_valid(++nv, 20);
    chk("sat_overrun", overrun, 0);

    // Integrator accumulation, then clr restarts it
    @(negedge ACLK) enable = 1'b0;
    do_clr();
    kp = '0; ki = 16'sh0100; setpoint = 16'sd10; feedback = 16'sd0; period = 32'd20;
    repeat (3) push_exp();
    @(negedge ACLK) enable = 1'b1;
    nv += 3;
    wait_valid(nv, 100);
    @(negedge ACLK) enable = 1'b0;
    chk("i_gap", last_gap, 20);
    do_clr();
    push_exp();
    @(negedge ACLK) enable = 1'b1;
    wait_valid(++nv, 40);
    @(negedge ACLK) enable = 1'b0;

    // Period below 8 clamps to 8
    do_clr();
    ki = '0; kp = 16'sh0100; setpoint = 16'sd5; period = 32'd3;
    repeat (2) push_exp();
    @(negedge ACLK) enable = 1'b1;
    nv += 2;
    wait_valid(nv, 40);
    @(negedge ACLK) enable = 1'b0;
    chk("clamp_gap", last_gap, 8);
    chk("clamp_overrun", overrun, 0);

`ifdef PID_DERIV_EN
    do_clr();
    kp = '0; kd = 16'sh0100; period = 32'd0;
    @(negedge ACLK) enable = 1'b1;
    setpoint = 16'sd0;  push_exp(); pulse_trig(); wait_valid(++nv, 20);
    setpoint = 16'sd50; push_exp(); pulse_trig(); wait_valid(++nv, 20);
    push_exp(); pulse_trig(); wait_valid(++nv, 20);
    kd = '0;
`endif

    // Overrun: second trig 3 cycles after the first is dropped
    period = 32'd0; enable = 1'b1;
    do_clr();
    kp = 16'sh0100; setpoint = 16'sd30; feedback = 16'sd0;
    push_exp();
    pulse_trig();
    @(negedge ACLK);
    pulse_trig();
    wait_valid(++nv, 20);
    repeat (8) @(posedge ACLK);
    chk("ovr_single_valid", nvalid, nv);
    chk("ovr_sticky", overrun, 1);

    // Abort: clr sampled 3 cycles after the tick
    pulse_trig();
    @(negedge ACLK);
    @(negedge ACLK) clr = 1'b1;
    @(negedge ACLK) clr = 1'b0;
    m_integ = 0; m_eprev = 0;
    chk("abort_busy", busy, 0);
    chk("abort_u", u, 0);
    chk("abort_u_valid", u_valid, 0);
    chk("abort_overrun", overrun, 0);
    repeat (10) @(posedge ACLK);
    chk("abort_no_valid", nvalid, nv);

    // Reset mid-computation after building nonzero u and overrun
    push_exp();
    pulse_trig();
    @(negedge ACLK);
    pulse_trig();
    wait_valid(++nv, 20);
    chk("pre_rst_overrun", overrun, 1);
    pulse_trig();
    @(posedge ACLK);
    #3 ARESETN = 1'b0;
    #1;
    chk("mid_rst_u", u, 0);
    chk("mid_rst_u_valid", u_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overrun", overrun, 0);
    @(negedge ACLK) ARESETN = 1'b1;
    m_integ = 0; m_eprev = 0;
    repeat (10) @(posedge ACLK);
    chk("rst_no_valid", nvalid, nv);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
